hub_fpu_issue_queue: RTL and testbench

Issue and retire stage sitting directly upstream and downstream of `fpnew_top` (FP16, `DEFAULT_NOREGS`). It buffers operation requests from the host in a small FIFO and dispatches them over the FPU input handshake with a rolling tag. It captures results into a registered response slot, checks return order, and accumulates sticky IEEE status flags. It also owns the FPU `flush_i` and a drain protocol.

---
 rtl/hub_fpu_seq_pkg.sv | 66 ++++++
 rtl/hub_fpu_req_fifo.sv | 60 ++++++
 rtl/hub_fpu_issue_queue.sv | 213 +++++++++++++++++++++
 tb/tb_hub_fpu_issue_queue.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_fpu_seq_pkg.sv
// Shared types for the FP16 issue/retire sequencer in front of fpnew_top.
// Holds the FPU encodings the sequencer needs, the queued request payload
// and the sequencer state enum.
package hub_fpu_seq_pkg;

  localparam int unsigned FP16_W    = 16;
  localparam int unsigned DEF_TAG_W = 3;
  localparam int unsigned NUM_OPS   = 3;
  localparam int unsigned STATUS_W  = 5;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  // IEEE exception flags in NV/DZ/OF/UF/NX order (NX is bit 0)
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  localparam fp_format_e  SEQ_FP_FMT  = FP16;
  localparam int_format_e SEQ_INT_FMT = INT16;

  typedef struct packed {
    operation_e                         op;
    logic                               op_mod;
    roundmode_e                         rnd;
    logic [NUM_OPS-1:0][FP16_W-1:0]     operands;
  } issue_req_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/hub_fpu_req_fifo.sv
// Request FIFO for the issue queue: DEPTH entries of issue_req_t.
// Ports: clk_i/rst_i (async active-high), push_i/pop_i (ignored when
// full/empty), clear_i (drops all entries, wins over push/pop),
// data_i (write payload), data_o (head entry), full_o, empty_o.
module hub_fpu_req_fifo
  import hub_fpu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       clear_i,
  input  issue_req_t data_i,
  output issue_req_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  issue_req_t       r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = push_i && !full_o && !clear_i;
  assign w_pop   = pop_i && !empty_o && !clear_i;
  assign data_o  = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Pointer update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/hub_fpu_issue_queue.sv
// Issue/retire stage around fpnew_top (FP16, no internal pipeline regs).
// Host side: req_* handshake into a request FIFO, rsp_* response slot,
// sticky fflags_o / tag_err_o, flush_i / drain_i control, drain_done_o pulse.
// FPU side: fpu_* request fields driven from the FIFO head with a rolling tag,
// fpu_in_valid_o/fpu_in_ready_i, fpu_result/status/tag with
// fpu_out_valid_i/fpu_out_ready_o, and fpu_flush_o.
// Observability: outstanding_o (in-flight ops), busy_o.
module hub_fpu_issue_queue
  import hub_fpu_seq_pkg::*;
#(
  parameter  int unsigned FP_WIDTH = FP16_W,
  parameter  int unsigned DEPTH    = 4,
  parameter  int unsigned MAX_OUT  = 4,
  parameter  int unsigned TAG_W    = DEF_TAG_W,
  localparam int unsigned OUT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  operation_e                       req_op_i,
  input  logic                             req_op_mod_i,
  input  roundmode_e                       req_rnd_i,
  input  logic [FP_WIDTH-1:0]              req_a_i,
  input  logic [FP_WIDTH-1:0]              req_b_i,
  input  logic [FP_WIDTH-1:0]              req_c_i,
  input  logic                             flush_i,
  input  logic                             drain_i,
  output logic                             drain_done_o,
  output logic [NUM_OPS-1:0][FP_WIDTH-1:0] fpu_operands_o,
  output operation_e                       fpu_op_o,
  output logic                             fpu_op_mod_o,
  output roundmode_e                       fpu_rnd_mode_o,
  output fp_format_e                       fpu_src_fmt_o,
  output fp_format_e                       fpu_dst_fmt_o,
  output int_format_e                      fpu_int_fmt_o,
  output logic [TAG_W-1:0]                 fpu_tag_o,
  output logic                             fpu_in_valid_o,
  input  logic                             fpu_in_ready_i,
  output logic                             fpu_flush_o,
  input  logic [FP_WIDTH-1:0]              fpu_result_i,
  input  status_t                          fpu_status_i,
  input  logic [TAG_W-1:0]                 fpu_tag_i,
  input  logic                             fpu_out_valid_i,
  output logic                             fpu_out_ready_o,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [FP_WIDTH-1:0]              rsp_result_o,
  output logic [STATUS_W-1:0]              rsp_status_o,
  output logic [TAG_W-1:0]                 rsp_tag_o,
  output logic [STATUS_W-1:0]              fflags_o,
  input  logic                             fflags_clr_i,
  output logic                             tag_err_o,
  output logic [OUT_W-1:0]                 outstanding_o,
  output logic                             busy_o
);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  issue_req_t          w_push_req;
  issue_req_t          w_head;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_push;
  logic                w_dispatch;
  logic                w_retire;
  logic                w_dec;
  logic                w_idle;
  logic                w_clear;
  logic [STATUS_W-1:0] w_status;

  logic [TAG_W-1:0]    r_issue_tag;
  logic [TAG_W-1:0]    r_expect_tag;
  logic [OUT_W-1:0]    r_outstanding;
  logic                r_rsp_valid;
  logic [FP_WIDTH-1:0] r_rsp_result;
  logic [STATUS_W-1:0] r_rsp_status;
  logic [TAG_W-1:0]    r_rsp_tag;
  logic [STATUS_W-1:0] r_fflags;
  logic                r_tag_err;

  assign w_push_req.op          = req_op_i;
  assign w_push_req.op_mod      = req_op_mod_i;
  assign w_push_req.rnd         = req_rnd_i;
  assign w_push_req.operands[0] = FP16_W'(req_a_i);
  assign w_push_req.operands[1] = FP16_W'(req_b_i);
  assign w_push_req.operands[2] = FP16_W'(req_c_i);

  assign w_clear = (r_state == FLUSH);

  hub_fpu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_dispatch),
    .clear_i (w_clear),
    .data_i  (w_push_req),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  // FPU request fields come straight from the FIFO head, so they hold while stalled
  assign fpu_operands_o[0] = FP_WIDTH'(w_head.operands[0]);
  assign fpu_operands_o[1] = FP_WIDTH'(w_head.operands[1]);
  assign fpu_operands_o[2] = FP_WIDTH'(w_head.operands[2]);
  assign fpu_op_o          = w_head.op;
  assign fpu_op_mod_o      = w_head.op_mod;
  assign fpu_rnd_mode_o    = w_head.rnd;
  assign fpu_src_fmt_o     = SEQ_FP_FMT;
  assign fpu_dst_fmt_o     = SEQ_FP_FMT;
  assign fpu_int_fmt_o     = SEQ_INT_FMT;
  assign fpu_tag_o         = r_issue_tag;

  assign w_idle          = w_fifo_empty && (r_outstanding == '0) && !r_rsp_valid;
  assign fpu_out_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_push          = req_valid_i && req_ready_o;
  assign w_dispatch      = fpu_in_valid_o && fpu_in_ready_i;
  // Results arriving during the flush cycle belong to aborted work
  assign w_retire        = fpu_out_valid_i && fpu_out_ready_o && (r_state != FLUSH);
  assign w_dec           = w_retire && (r_outstanding != '0);
  assign w_status        = fpu_status_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  // Next state and control outputs; flush beats drain
  always_comb begin
    w_state_nxt    = r_state;
    req_ready_o    = 1'b0;
    drain_done_o   = 1'b0;
    fpu_flush_o    = 1'b0;
    fpu_in_valid_o = 1'b0;
    unique case (r_state)
      RUN: begin
        if (flush_i)      w_state_nxt = FLUSH;
        else if (drain_i) w_state_nxt = DRAIN;
        req_ready_o = !w_fifo_full && !flush_i && !drain_i;
      end
      DRAIN: begin
        if (flush_i)     w_state_nxt = FLUSH;
        else if (w_idle) w_state_nxt = RUN;
        drain_done_o = w_idle;
      end
      FLUSH: begin
        w_state_nxt = RUN;
        fpu_flush_o = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
    if (r_state != FLUSH)
      fpu_in_valid_o = !w_fifo_empty && (r_outstanding < OUT_W'(MAX_OUT));
  end

  // Sticky flags; a clear coinciding with a retire keeps only the new status
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fflags  <= '0;
      r_tag_err <= 1'b0;
    end else begin
      if (fflags_clr_i) r_fflags <= w_retire ? w_status : '0;
      else if (w_retire) r_fflags <= r_fflags | w_status;
      if (w_retire && ((fpu_tag_i != r_expect_tag) || (r_outstanding == '0)))
        r_tag_err <= 1'b1;
    end
  end

  // Tags, in-flight count and response slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_issue_tag   <= '0;
      r_expect_tag  <= '0;
      r_outstanding <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_status  <= '0;
      r_rsp_tag     <= '0;
    end else if (r_state == FLUSH) begin
      r_issue_tag   <= '0;
      r_expect_tag  <= '0;
      r_outstanding <= '0;
      r_rsp_valid   <= 1'b0;
    end else begin
      if (w_dispatch) r_issue_tag <= r_issue_tag + TAG_W'(1);
      if (w_retire) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= fpu_result_i;
        r_rsp_status <= w_status;
        r_rsp_tag    <= fpu_tag_i;
        r_expect_tag <= r_expect_tag + TAG_W'(1);
      end else if (rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_dispatch && !w_dec)      r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_dispatch && w_dec) r_outstanding <= r_outstanding - OUT_W'(1);
    end
  end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_result_o  = r_rsp_result;
  assign rsp_status_o  = r_rsp_status;
  assign rsp_tag_o     = r_rsp_tag;
  assign fflags_o      = r_fflags;
  assign tag_err_o     = r_tag_err;
  assign outstanding_o = r_outstanding;
  assign busy_o        = !w_idle;

endmodule

// File: tb/tb_hub_fpu_issue_queue.sv
// Directed bench for hub_fpu_issue_queue. u_dut uses default parameters;
// u_dut2 (MAX_OUT=2) shares the same stimulus and is checked in the
// in-flight limit scenario.
module tb_hub_fpu_issue_queue;
  import hub_fpu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst;
  logic        req_valid;
  operation_e  req_op;
  logic        req_op_mod;
  roundmode_e  req_rnd;
  logic [15:0] req_a, req_b, req_c;
  logic        flush, drain, fpu_in_ready, fpu_out_valid, rsp_ready, fflags_clr;
  logic [15:0] fpu_result;
  status_t     fpu_status;
  logic [2:0]  fpu_tag_in;

  logic             req_ready, drain_done, fpu_op_mod, fpu_in_valid, fpu_flush;
  logic             fpu_out_ready, rsp_valid, tag_err, busy;
  logic [2:0][15:0] fpu_operands;
  operation_e       fpu_op;
  roundmode_e       fpu_rnd;
  fp_format_e       src_fmt, dst_fmt;
  int_format_e      int_fmt;
  logic [2:0]       fpu_tag, rsp_tag, outstanding;
  logic [15:0]      rsp_result;
  logic [4:0]       rsp_status, fflags;

  logic             d2_req_ready, d2_drain_done, d2_fpu_op_mod, d2_in_valid, d2_fpu_flush;
  logic             d2_out_ready, d2_rsp_valid, d2_tag_err, d2_busy;
  logic [2:0][15:0] d2_operands;
  operation_e       d2_fpu_op;
  roundmode_e       d2_fpu_rnd;
  fp_format_e       d2_src_fmt, d2_dst_fmt;
  int_format_e      d2_int_fmt;
  logic [2:0]       d2_fpu_tag, d2_rsp_tag;
  logic [1:0]       d2_outstanding;
  logic [15:0]      d2_rsp_result;
  logic [4:0]       d2_rsp_status, d2_fflags;

  hub_fpu_issue_queue u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_op_mod_i(req_op_mod), .req_rnd_i(req_rnd),
    .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
    .flush_i(flush), .drain_i(drain), .drain_done_o(drain_done),
    .fpu_operands_o(fpu_operands), .fpu_op_o(fpu_op), .fpu_op_mod_o(fpu_op_mod),
    .fpu_rnd_mode_o(fpu_rnd), .fpu_src_fmt_o(src_fmt), .fpu_dst_fmt_o(dst_fmt),
    .fpu_int_fmt_o(int_fmt), .fpu_tag_o(fpu_tag),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_flush_o(fpu_flush),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
    .fflags_o(fflags), .fflags_clr_i(fflags_clr), .tag_err_o(tag_err),
    .outstanding_o(outstanding), .busy_o(busy)
  );

  hub_fpu_issue_queue #(.MAX_OUT(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(d2_req_ready),
    .req_op_i(req_op), .req_op_mod_i(req_op_mod), .req_rnd_i(req_rnd),
    .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c),
    .flush_i(flush), .drain_i(drain), .drain_done_o(d2_drain_done),
    .fpu_operands_o(d2_operands), .fpu_op_o(d2_fpu_op), .fpu_op_mod_o(d2_fpu_op_mod),
    .fpu_rnd_mode_o(d2_fpu_rnd), .fpu_src_fmt_o(d2_src_fmt), .fpu_dst_fmt_o(d2_dst_fmt),
    .fpu_int_fmt_o(d2_int_fmt), .fpu_tag_o(d2_fpu_tag),
    .fpu_in_valid_o(d2_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_flush_o(d2_fpu_flush),
    .fpu_result_i(fpu_result), .fpu_status_i(fpu_status), .fpu_tag_i(fpu_tag_in),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(d2_out_ready),
    .rsp_valid_o(d2_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(d2_rsp_result),
    .rsp_status_o(d2_rsp_status), .rsp_tag_o(d2_rsp_tag),
    .fflags_o(d2_fflags), .fflags_clr_i(fflags_clr), .tag_err_o(d2_tag_err),
    .outstanding_o(d2_outstanding), .busy_o(d2_busy)
  );

  task automatic init_inputs();
    req_valid = 0; req_op = ADD; req_op_mod = 0; req_rnd = RNE;
    req_a = 0; req_b = 0; req_c = 0;
    flush = 0; drain = 0; fpu_in_ready = 0; fpu_out_valid = 0;
    rsp_ready = 0; fflags_clr = 0; fpu_result = 0;
    fpu_status = status_t'(5'b00000); fpu_tag_in = 0;
  endtask

  // Inputs change and outputs are sampled 2 ns after the rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    init_inputs();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (fpu_in_valid !== 1'b0) begin bad++; $display("FAIL reset_in_valid got=%0b exp=0", fpu_in_valid); end
    total++; if (fpu_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", fpu_flush); end
    total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%0b exp=0", drain_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if (fflags !== 5'd0) begin bad++; $display("FAIL reset_fflags got=%b exp=00000", fflags); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%0b exp=0", tag_err); end
    total++; if (src_fmt !== FP16 || dst_fmt !== FP16) begin bad++; $display("FAIL fmt_fp got=%0d/%0d exp=2/2", src_fmt, dst_fmt); end
    total++; if (int_fmt !== INT16) begin bad++; $display("FAIL fmt_int got=%0d exp=1", int_fmt); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    apply_reset();
    fpu_in_ready = 1; rsp_ready = 1;
    req_valid = 1; req_op = MUL; req_a = 16'h3C00; req_b = 16'h4000; req_c = 16'h0000;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL single_accept got=%0b exp=1", req_ready); end
    total++; if (fpu_in_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%0b exp=0", fpu_in_valid); end
    cyc();
    req_valid = 0; #1;
    total++; if (fpu_in_valid !== 1'b1) begin bad++; $display("FAIL single_in_valid got=%0b exp=1", fpu_in_valid); end
    total++; if (fpu_tag !== 3'd0) begin bad++; $display("FAIL single_tag got=%0d exp=0", fpu_tag); end
    total++; if (fpu_operands[0] !== 16'h3C00 || fpu_operands[1] !== 16'h4000) begin bad++; $display("FAIL single_operands got=%h/%h exp=3c00/4000", fpu_operands[0], fpu_operands[1]); end
    total++; if (fpu_op !== MUL) begin bad++; $display("FAIL single_op got=%0d exp=%0d", fpu_op, MUL); end
    cyc();
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL single_outstanding got=%0d exp=1", outstanding); end
    total++; if (fpu_in_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%0b exp=0", fpu_in_valid); end
    cyc();
    fpu_out_valid = 1; fpu_result = 16'h3C00; fpu_status = status_t'(5'b00001); fpu_tag_in = 0; #1;
    total++; if (fpu_out_ready !== 1'b1) begin bad++; $display("FAIL single_out_ready got=%0b exp=1", fpu_out_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_early got=%0b exp=0", rsp_valid); end
    cyc();
    fpu_out_valid = 0; #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
    total++; if (rsp_result !== 16'h3C00) begin bad++; $display("FAIL single_rsp_result got=%h exp=3c00", rsp_result); end
    total++; if (rsp_tag !== 3'd0) begin bad++; $display("FAIL single_rsp_tag got=%0d exp=0", rsp_tag); end
    total++; if (rsp_status !== 5'b00001) begin bad++; $display("FAIL single_rsp_status got=%b exp=00001", rsp_status); end
    total++; if (fflags !== 5'b00001) begin bad++; $display("FAIL single_fflags got=%b exp=00001", fflags); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL single_retired got=%0d exp=0", outstanding); end
    cyc();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=rsp%0b/busy%0b exp=0/0", rsp_valid, busy); end
  endtask

  task automatic test_stall();
    apply_reset();
    fpu_in_ready = 0; rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_a = 16'(i + 1); #1;
      total++; if (req_ready !== 1'(i < 4)) begin bad++; $display("FAIL stall_ready_%0d got=%0b exp=%0b", i, req_ready, (i < 4)); end
      cyc();
    end
    req_valid = 0; fpu_in_ready = 1; #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (fpu_in_valid !== 1'b1 || fpu_tag !== 3'(i) || fpu_operands[0] !== 16'(i + 1))
        begin bad++; $display("FAIL stall_dispatch_%0d got=v%0b t%0d a%h exp=v1 t%0d a%h", i, fpu_in_valid, fpu_tag, fpu_operands[0], i, i + 1); end
      cyc();
    end
    total++; if (fpu_in_valid !== 1'b0 || outstanding !== 3'd4) begin bad++; $display("FAIL stall_end got=v%0b o%0d exp=v0 o4", fpu_in_valid, outstanding); end
  endtask

  task automatic test_max_out();
    int n = 0;
    apply_reset();
    fpu_in_ready = 1; rsp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i < 3); req_a = 16'(16'h100 + i); #1;
      if (d2_in_valid && fpu_in_ready) n++;
      cyc();
    end
    req_valid = 0;
    total++; if (n !== 2) begin bad++; $display("FAIL maxout_dispatches got=%0d exp=2", n); end
    total++; if (d2_outstanding !== 2'd2 || d2_in_valid !== 1'b0) begin bad++; $display("FAIL maxout_limit got=o%0d v%0b exp=o2 v0", d2_outstanding, d2_in_valid); end
    fpu_out_valid = 1; fpu_tag_in = 0; fpu_status = status_t'(5'b00000);
    cyc();
    fpu_out_valid = 0; #1;
    total++; if (d2_outstanding !== 2'd1 || d2_in_valid !== 1'b1 || d2_fpu_tag !== 3'd2 || d2_operands[0] !== 16'h102)
      begin bad++; $display("FAIL maxout_third got=o%0d v%0b t%0d a%h exp=o1 v1 t2 a0102", d2_outstanding, d2_in_valid, d2_fpu_tag, d2_operands[0]); end
    cyc();
    total++; if (d2_outstanding !== 2'd2 || d2_in_valid !== 1'b0 || d2_tag_err !== 1'b0) begin bad++; $display("FAIL maxout_refill got=o%0d v%0b e%0b exp=o2 v0 e0", d2_outstanding, d2_in_valid, d2_tag_err); end
  endtask

  task automatic test_tag_err();
    apply_reset();
    fpu_in_ready = 1; rsp_ready = 1;
    req_valid = 1; req_a = 16'h4200; cyc();
    req_valid = 0; cyc();
    fpu_out_valid = 1; fpu_tag_in = 3'd1; #1;
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL tagerr_before got=%0b exp=0", tag_err); end
    cyc();
    fpu_out_valid = 0; #1;
    total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL tagerr_set got=%0b exp=1", tag_err); end
    flush = 1; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL tagerr_ready_flush got=%0b exp=0", req_ready); end
    cyc();
    flush = 0; #1;
    total++; if (fpu_flush !== 1'b1 || tag_err !== 1'b1) begin bad++; $display("FAIL tagerr_in_flush got=f%0b e%0b exp=f1 e1", fpu_flush, tag_err); end
    cyc();
    total++; if (fpu_flush !== 1'b0 || tag_err !== 1'b1) begin bad++; $display("FAIL tagerr_after_flush got=f%0b e%0b exp=f0 e1", fpu_flush, tag_err); end
  endtask

  task automatic test_flush();
    apply_reset();
    fpu_in_ready = 0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; req_a = 16'(16'h10 + i); cyc();
    end
    req_valid = 0; fpu_in_ready = 1; cyc();
    req_valid = 1; req_a = 16'h20; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL flush_refill_ready got=%0b exp=1", req_ready); end
    cyc();
    req_valid = 0; fpu_in_ready = 0; #1;
    total++; if (outstanding !== 3'd2 || busy !== 1'b1 || fpu_in_valid !== 1'b1) begin bad++; $display("FAIL flush_setup got=o%0d b%0b v%0b exp=o2 b1 v1", outstanding, busy, fpu_in_valid); end
    flush = 1; cyc();
    flush = 0; #1;
    total++; if (fpu_flush !== 1'b1 || fpu_in_valid !== 1'b0) begin bad++; $display("FAIL flush_pulse got=f%0b v%0b exp=f1 v0", fpu_flush, fpu_in_valid); end
    cyc();
    total++; if (fpu_flush !== 1'b0 || outstanding !== 3'd0 || busy !== 1'b0 || req_ready !== 1'b1)
      begin bad++; $display("FAIL flush_cleared got=f%0b o%0d b%0b r%0b exp=f0 o0 b0 r1", fpu_flush, outstanding, busy, req_ready); end
    fpu_in_ready = 1; req_valid = 1; req_a = 16'h0055; cyc();
    req_valid = 0; #1;
    total++; if (fpu_in_valid !== 1'b1 || fpu_tag !== 3'd0 || fpu_operands[0] !== 16'h0055)
      begin bad++; $display("FAIL flush_next_tag got=v%0b t%0d a%h exp=v1 t0 a0055", fpu_in_valid, fpu_tag, fpu_operands[0]); end
    cyc();
  endtask

  task automatic test_drain();
    apply_reset();
    fpu_in_ready = 0; rsp_ready = 1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1; req_a = 16'(16'h30 + i); cyc();
    end
    drain = 1; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL drain_ready_comb got=%0b exp=0", req_ready); end
    cyc();
    req_valid = 0; drain = 0; fpu_in_ready = 1; #1;
    total++; if (req_ready !== 1'b0 || drain_done !== 1'b0) begin bad++; $display("FAIL drain_state got=r%0b d%0b exp=r0 d0", req_ready, drain_done); end
    cyc(); cyc();
    fpu_out_valid = 1; fpu_tag_in = 0; fpu_result = 16'h1111; fpu_status = status_t'(5'b00100);
    cyc();
    fpu_tag_in = 1; fpu_result = 16'h2222; fpu_status = status_t'(5'b00001); fflags_clr = 1; #1;
    total++; if (rsp_tag !== 3'd0 || fflags !== 5'b00100) begin bad++; $display("FAIL drain_first got=t%0d f%b exp=t0 f00100", rsp_tag, fflags); end
    cyc();
    fpu_out_valid = 0; fflags_clr = 0; rsp_ready = 0; #1;
    total++; if (fflags !== 5'b00001) begin bad++; $display("FAIL clr_with_retire got=%b exp=00001", fflags); end
    total++; if (rsp_valid !== 1'b1 || rsp_tag !== 3'd1 || outstanding !== 3'd0) begin bad++; $display("FAIL drain_second got=v%0b t%0d o%0d exp=v1 t1 o0", rsp_valid, rsp_tag, outstanding); end
    total++; if (drain_done !== 1'b0 || req_ready !== 1'b0 || fpu_out_ready !== 1'b0) begin bad++; $display("FAIL drain_hold got=d%0b r%0b or%0b exp=d0 r0 or0", drain_done, req_ready, fpu_out_ready); end
    cyc();
    total++; if (rsp_valid !== 1'b1 || drain_done !== 1'b0) begin bad++; $display("FAIL drain_stalled got=v%0b d%0b exp=v1 d0", rsp_valid, drain_done); end
    rsp_ready = 1; #1;
    total++; if (fpu_out_ready !== 1'b1) begin bad++; $display("FAIL out_ready_comb got=%0b exp=1", fpu_out_ready); end
    cyc();
    total++; if (drain_done !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL drain_done_pulse got=d%0b r%0b exp=d1 r0", drain_done, req_ready); end
    cyc();
    total++; if (drain_done !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL drain_resume got=d%0b r%0b exp=d0 r1", drain_done, req_ready); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    fpu_in_ready = 0; rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1; req_a = 16'(16'h40 + i); cyc();
    end
    req_valid = 0; fpu_in_ready = 1;
    cyc(); cyc(); cyc();
    fpu_in_ready = 0; #1;
    total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL b2b_outstanding got=%0d exp=3", outstanding); end
    for (int i = 0; i < 3; i++) begin
      fpu_out_valid = 1; fpu_tag_in = 3'(i); fpu_result = 16'(16'h40 + i); fpu_status = status_t'(5'b00000); #1;
      total++; if (fpu_out_ready !== 1'b1) begin bad++; $display("FAIL b2b_out_ready_%0d got=%0b exp=1", i, fpu_out_ready); end
      cyc();
      total++; if (rsp_valid !== 1'b1 || rsp_tag !== 3'(i) || rsp_result !== 16'(16'h40 + i))
        begin bad++; $display("FAIL b2b_rsp_%0d got=v%0b t%0d r%h exp=v1 t%0d r%h", i, rsp_valid, rsp_tag, rsp_result, i, 16'h40 + i); end
    end
    fpu_out_valid = 0;
    cyc();
    total++; if (rsp_valid !== 1'b0 || outstanding !== 3'd0 || tag_err !== 1'b0) begin bad++; $display("FAIL b2b_end got=v%0b o%0d e%0b exp=v0 o0 e0", rsp_valid, outstanding, tag_err); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_op();
    test_stall();
    test_max_out();
    test_tag_err();
    test_flush();
    test_drain();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
